// File: rtl/seq_pattern_gen.sv
// Serial frame transmitter: sync pattern, MSB-first payload, idle gap.
// Define SEQ_GEN_PARITY_EN to append one even-parity bit per frame.
module seq_pattern_gen #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1001,
  parameter int                GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              op,
  output logic              op_valid,
  output logic              frame_done
);

  localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAXW   = (MAX_SD > GAP) ? MAX_SD : GAP;
  localparam int CW     = $clog2(MAXW) + 1;
  localparam int FW     = SYNC_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
`ifdef SEQ_GEN_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [FW-1:0]   fr, fr_nxt;
  logic            op_nxt;
  logic            op_valid_nxt;
  logic            frame_done_nxt;
`ifdef SEQ_GEN_PARITY_EN
  logic            par, par_nxt;
`endif

  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      fr         <= '0;
      op         <= 1'b0;
      op_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      fr         <= fr_nxt;
      op         <= op_nxt;
      op_valid   <= op_valid_nxt;
      frame_done <= frame_done_nxt;
    end
  end

`ifdef SEQ_GEN_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par <= 1'b0;
    else      par <= par_nxt;
  end
`endif

  // The state register names the bit being driven onto op,
  // so outputs are decoded from the next state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fr_nxt    = fr;
`ifdef SEQ_GEN_PARITY_EN
    par_nxt   = par;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SYNC;
          cnt_nxt   = CW'(SYNC_W - 1);
          fr_nxt    = {SYNC_PAT, data_in};
`ifdef SEQ_GEN_PARITY_EN
          par_nxt   = ^data_in;
`endif
        end
      end
      S_SYNC: begin
        if (cnt == '0) begin
          state_nxt = S_DATA;
          cnt_nxt   = CW'(DATA_W - 1);
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_nxt = S_PAR;
          cnt_nxt   = '0;
`else
          state_nxt = S_GAP;
          cnt_nxt   = CW'(GAP - 1);
`endif
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        state_nxt = S_GAP;
        cnt_nxt   = CW'(GAP - 1);
      end
`endif
      S_GAP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    op_nxt = 1'b0;
    unique case (1'b1)
      (state_nxt == S_SYNC),
      (state_nxt == S_DATA): begin
        op_nxt = fr_nxt[FW-1];
        fr_nxt = {fr_nxt[FW-2:0], 1'b0};
      end
`ifdef SEQ_GEN_PARITY_EN
      (state_nxt == S_PAR): op_nxt = par_nxt;
`endif
      default: ;
    endcase

    op_valid_nxt = (state_nxt != S_IDLE) && (state_nxt != S_GAP);
`ifdef SEQ_GEN_PARITY_EN
    frame_done_nxt = (state_nxt == S_PAR);
`else
    frame_done_nxt = (state_nxt == S_DATA) && (cnt_nxt == '0);
`endif
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with a behavioural 1001 detector.
// Expected frames switch with SEQ_GEN_PARITY_EN.
module tb_seq_pattern_gen;

  localparam int GAP = 2;
`ifdef SEQ_GEN_PARITY_EN
  localparam int L = 13;
  localparam logic [L-1:0] F_A5 = 13'b1001_10100101_0;
  localparam logic [L-1:0] F_FF = 13'b1001_11111111_0;
  localparam logic [L-1:0] F_00 = 13'b1001_00000000_0;
  localparam logic [L-1:0] F_07 = 13'b1001_00000111_1;
`else
  localparam int L = 12;
  localparam logic [L-1:0] F_A5 = 12'b1001_10100101;
  localparam logic [L-1:0] F_FF = 12'b1001_11111111;
  localparam logic [L-1:0] F_00 = 12'b1001_00000000;
  localparam logic [L-1:0] F_07 = 12'b1001_00000111;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = '0;
  logic       ready, busy, op, op_valid, frame_done;

  int checks = 0;
  int failures = 0;

  logic [2:0] hist = '0;
  int         hits = 0;
  logic       match;

  seq_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .ready      (ready),
    .busy       (busy),
    .op         (op),
    .op_valid   (op_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign match = ({hist, op} == 4'b1001);

  always @(posedge clk) begin
    hist <= {hist[1:0], op};
    if (match) hits <= hits + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    data_in = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 ||
          op_valid !== 1'b0 || op !== 1'b0) begin
        failures++;
        $display("FAIL reset cyc%0d: ready=%b busy=%b vld=%b op=%b want 1 0 0 0",
                 i, ready, busy, op_valid, op);
      end
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset frame_done: got %b want 0", frame_done);
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [L-1:0] e;
    e = F_A5;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL single pre-ready: got %b want 1", ready);
    end
    start = 1'b1;
    data_in = 8'hA5;
    tick();
    start = 1'b0;
    data_in = 8'h3C;
    for (int k = 0; k < L; k++) begin
      checks++;
      if (op !== e[L-1-k] || op_valid !== 1'b1 ||
          frame_done !== (k == L-1) || busy !== 1'b1) begin
        failures++;
        $display("FAIL single bit%0d: op=%b vld=%b fd=%b busy=%b want op=%b 1 %b 1",
                 k, op, op_valid, frame_done, busy, e[L-1-k], (k == L-1));
      end
      tick();
    end
    for (int g = 0; g < GAP; g++) begin
      checks++;
      if (ready !== 1'b0 || op_valid !== 1'b0 ||
          op !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL single gap%0d: ready=%b vld=%b op=%b fd=%b want 0 0 0 0",
                 g, ready, op_valid, op, frame_done);
      end
      tick();
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single post-ready: ready=%b busy=%b want 1 0", ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] e;
    start = 1'b1;
    data_in = 8'hFF;
    tick();
    data_in = 8'h00;
    e = F_FF;
    for (int k = 0; k < L; k++) begin
      checks++;
      if (op !== e[L-1-k] || op_valid !== 1'b1 || frame_done !== (k == L-1)) begin
        failures++;
        $display("FAIL b2b f1 bit%0d: op=%b vld=%b fd=%b want %b 1 %b",
                 k, op, op_valid, frame_done, e[L-1-k], (k == L-1));
      end
      tick();
    end
    for (int g = 0; g < GAP; g++) begin
      checks++;
      if (ready !== 1'b0 || op_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b gap%0d: ready=%b vld=%b want 0 0", g, ready, op_valid);
      end
      tick();
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b ready: got %b want 1", ready);
    end
    tick();
    e = F_00;
    for (int k = 0; k < L; k++) begin
      checks++;
      if (op !== e[L-1-k] || op_valid !== 1'b1 || frame_done !== (k == L-1)) begin
        failures++;
        $display("FAIL b2b f2 bit%0d: op=%b vld=%b fd=%b want %b 1 %b",
                 k, op, op_valid, frame_done, e[L-1-k], (k == L-1));
      end
      tick();
    end
    start = 1'b0;
    repeat (GAP) tick();
    checks++;
    if (ready !== 1'b1 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b end: ready=%b vld=%b want 1 0", ready, op_valid);
    end
  endtask

  task automatic test_abort();
    logic [L-1:0] e;
    start = 1'b1;
    data_in = 8'hA5;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (op_valid !== 1'b1 || op !== 1'b1) begin
      failures++;
      $display("FAIL abort pre: vld=%b op=%b want 1 1", op_valid, op);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_valid !== 1'b0 || op !== 1'b0 || frame_done !== 1'b0 ||
        ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort async: vld=%b op=%b fd=%b ready=%b busy=%b want 0 0 0 1 0",
               op_valid, op, frame_done, ready, busy);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort resume: ready=%b vld=%b want 1 0", ready, op_valid);
    end
    start = 1'b1;
    data_in = 8'h07;
    tick();
    start = 1'b0;
    e = F_07;
    for (int k = 0; k < L; k++) begin
      checks++;
      if (op !== e[L-1-k] || op_valid !== 1'b1 || frame_done !== (k == L-1)) begin
        failures++;
        $display("FAIL abort frame bit%0d: op=%b vld=%b fd=%b want %b 1 %b",
                 k, op, op_valid, frame_done, e[L-1-k], (k == L-1));
      end
      tick();
    end
    repeat (GAP) tick();
  endtask

  task automatic test_loopback();
    int h0;
    for (int f = 0; f < 2; f++) begin
      h0 = hits;
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL loop%0d ready: got %b want 1", f, ready);
      end
      start = 1'b1;
      data_in = 8'h00;
      tick();
      start = 1'b0;
      for (int k = 0; k < L; k++) begin
        checks++;
        if (match !== (k == 3)) begin
          failures++;
          $display("FAIL loop%0d det bit%0d: got %b want %b", f, k, match, (k == 3));
        end
        tick();
      end
      repeat (GAP) tick();
      checks++;
      if (hits - h0 !== 1) begin
        failures++;
        $display("FAIL loop%0d hits: got %0d want 1", f, hits - h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial frame transmitter that generates the bitstream consumed by the team's serial sequence detectors. On a start request it latches a parallel payload and emits one bit per clock: first a fixed sync pattern (default 1001), then the payload MSB-first, then a minimum idle gap. It sits upstream of a detector instance on the same clock, driving that detector's `ip` input.

## Interface
- `DATA_W`, 8: payload width in bits; must be 1–32.
- `SYNC_W`, 4: sync pattern width; must be 1–8.
- `SYNC_PAT`, 4'b1001: sync pattern, transmitted MSB-first.
- `GAP`, 2: idle cycles after each frame; must be ≥1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only when `ready`=1.
- `data_in`  in  DATA_W  payload; latched on the accepting edge.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `op`  out  1  serial bit; 0 when `op_valid`=0.
- `op_valid`  out  1  high while a sync, payload or parity bit is on `op`.
- `frame_done`  out  1  one-cycle pulse, coincident with the last bit of the frame.

## Operation
- States:
  - IDLE → SYNC on `start`=1 and `ready`=1.
  - SYNC → DATA after SYNC_W bits.
  - DATA → PARITY (macro on) or GAP after DATA_W bits.
  - PARITY → GAP after 1 bit.
  - GAP → IDLE after GAP cycles.
- Accept: at a rising edge with `ready`=1 and `start`=1:
  - `data_in` is copied into the shift register.
  - The bit counter loads for SYNC.
- `start` is ignored in any state except IDLE. `data_in` is don't-care outside the accepting edge.
- SYNC: `op` = SYNC_PAT[SYNC_W-1-k] in the k-th SYNC cycle.
- DATA: `op` = shift-register MSB. The register shifts left by 1 each cycle and fills with 0.
- PARITY: `op` = XOR of all bits of the latched payload (even parity).
- GAP: `op`=0 and `op_valid`=0.
- Bit counter:
  - Width is $clog2 of the largest of SYNC_W, DATA_W and GAP, plus 1.
  - It reloads on every state entry and counts down to 0.
  - It never wraps; a terminal count forces the state transition.
- The frame_done flag is high exactly in the last `op_valid` cycle of the frame:
  - the last payload bit when the parity feature is compiled out;
  - the parity bit when it is compiled in.
- Reset mid-frame: on `rst` low, immediately and asynchronously:
  - state → IDLE;
  - `op`, `op_valid`, `frame_done`, `busy` → 0;
  - `ready` → 1.
  - The partial frame is discarded and not resumed.

## Timing
- `op`, `op_valid` and `frame_done` are registered; no combinational path from any input to them.
- `ready` and `busy` are decoded from the state register.
- Reset values: `op`=0, `op_valid`=0, `frame_done`=0, `busy`=0, `ready`=1.
- Latency: start accepted at edge E0 → first sync bit valid after E0. Bit k of the frame is valid after edge E0+k.
- Frame length: L = SYNC_W + DATA_W (+1 with the parity feature).
- `op_valid` is high for exactly L consecutive cycles, with no bubbles.
- GAP cycles follow the last bit; `ready` rises after edge E0+L+GAP.
- The earliest next accept is edge E0+L+GAP+1.
  - Back-to-back period: L+GAP+1 cycles (15 at defaults, macro off).

## Configuration
- `SEQ_GEN_PARITY_EN`:
  - When defined, adds the PARITY state: one even-parity bit after the payload. L grows by 1, and `frame_done` moves to the parity bit.
  - When undefined, there is no PARITY state and no parity logic; DATA → GAP directly.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 → `ready`=1, `busy`=0, `op_valid`=0, `op`=0 throughout. No frame starts until after `rst` rises.
- Single frame, defaults, macro off, `data_in`=8'hA5:
  - `op` after E0..E11 = 1,0,0,1,1,0,1,0,0,1,0,1, with `op_valid`=1 for those 12 cycles.
  - `frame_done`=1 only after E11; `ready`=1 after E14.
- `start` held high continuously with `data_in`=8'hFF then 8'h00:
  - Frames start at E0 and E15.
  - Second-frame `op` = 1,0,0,1 followed by eight 0s.
  - Changes to `data_in` during the first frame have no effect.
- Parity on (`SEQ_GEN_PARITY_EN`), `data_in`=8'h07:
  - 13 valid bits: 1,0,0,1,0,0,0,0,0,1,1,1, then 1.
  - `frame_done` is on the 13th bit.
- Mid-frame abort: assert `rst`=0 during the 3rd payload bit.
  - `op_valid` drops to 0 immediately.
  - After `rst` releases, a new start emits a complete, correct frame from the first sync bit.
- Loopback: connect `op` to a 1001 detector instance and send `data_in`=8'h00 → the detector fires exactly once per frame, on the 4th sync bit.
